// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spike_pkg
//  Description : Shared FSM state encoding and signature update function
//                for the spike collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package spike_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_SIG_W = 32;

    // Rotate-left-by-one then XOR in the (already folded) packet word.
    function automatic logic [c_SIG_W-1:0] sig_step(
        input logic [c_SIG_W-1:0] sig,
        input logic [c_SIG_W-1:0] word
    );
        return {sig[c_SIG_W-2:0], sig[c_SIG_W-1]} ^ word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spike_fifo
//  Description : Synchronous FIFO with registered storage and a registered
//                occupancy count; read data is the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int PKT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                 neu_clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PKT_WIDTH-1:0] din,
    output logic [PKT_WIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_AW:0]     count
);

    localparam logic [FIFO_AW:0] c_FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [PKT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign full   = (r_count == c_FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge neu_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are FIFO_AW bits wide, so they wrap modulo FIFO_DEPTH naturally.
    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_collector.sv
`default_nettype none
// ============================================================================
//  Module      : spike_collector
//  Description : Buffers router spike packets, counts pops per time step,
//                folds packets into a signature and flags end of run.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_collector
    import spike_pkg::*;
#(
    parameter int PKT_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2,
    parameter int STEP_NUMBER  = 32,
    parameter int CLK_PER_STEP = 64,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 neu_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PKT_WIDTH-1:0] packet_in,
    input  logic                 write_enable,
    output logic                 receive_full,
    output logic [7:0]           step_index,
    output logic [CNT_WIDTH-1:0] spike_count,
    output logic [31:0]          signature,
    output logic                 done,
    output logic                 overflow,
    output logic                 step_err
);

    localparam int                   c_CYC_W     = $clog2(CLK_PER_STEP + 1);
    localparam int                   c_NCHUNK    = (PKT_WIDTH + 31) / 32;
    localparam logic [c_CYC_W-1:0]   c_CYC_LIMIT = c_CYC_W'(CLK_PER_STEP);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [7:0]           c_LAST_STEP = 8'(STEP_NUMBER - 1);
    localparam logic [FIFO_AW:0]     c_FULL_CNT  = (FIFO_AW+1)'(FIFO_DEPTH);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_running;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [7:0]           r_step_index;
    logic [CNT_WIDTH-1:0] r_spike_count;
    logic [31:0]          r_signature;
    logic                 r_done;
    logic                 r_overflow;
    logic                 r_step_err;

    logic                     w_active;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [FIFO_AW:0]         w_count;
    logic [PKT_WIDTH-1:0]     w_dout;
    logic [c_NCHUNK*32-1:0]   w_pad;
    logic [31:0]              w_word;
    logic [CNT_WIDTH-1:0]     w_run_next;

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign receive_full = w_active && (w_count == c_FULL_CNT);
    assign w_push       = w_active && write_enable && !w_full;
    assign w_pop        = w_active && !w_empty;

    spike_fifo #(
        .PKT_WIDTH  (PKT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .neu_clk (neu_clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (packet_in),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Zero-extend to a multiple of 32 bits, then XOR-fold down to one word.
    always_comb begin
        w_pad                 = '0;
        w_pad[PKT_WIDTH-1:0]  = w_dout;
        w_word                = '0;
        for (int i = 0; i < c_NCHUNK; i++) begin
            w_word = w_word ^ w_pad[i*32 +: 32];
        end
    end

    assign w_run_next = (w_pop && (r_running != c_CNT_MAX)) ? r_running + 1'b1 : r_running;

    always_ff @(posedge neu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_running     <= '0;
            r_cyc         <= '0;
            r_step_index  <= '0;
            r_spike_count <= '0;
            r_signature   <= '0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_step_err    <= 1'b0;
        end else begin
            if (w_pop) r_signature <= sig_step(r_signature, w_word);
            if (write_enable && receive_full) r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_step_index <= '0;
                        r_running    <= '0;
                        r_cyc        <= '0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        r_spike_count <= w_run_next;
                        r_running     <= '0;
                        r_cyc         <= '0;
                        if (r_step_index == c_LAST_STEP) r_state <= ST_FLUSH;
                        else                             r_step_index <= r_step_index + 8'd1;
                    end else begin
                        r_running <= w_run_next;
                        if (r_cyc != c_CYC_LIMIT) r_cyc <= r_cyc + 1'b1;
                        // Flag on the same edge cyc reaches the limit.
                        if (r_cyc == c_CYC_LIMIT - 1'b1) r_step_err <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_running <= w_run_next;
                    if (w_empty) begin
                        r_state       <= ST_DONE;
                        r_spike_count <= r_running;
                        r_done        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign step_index  = r_step_index;
    assign spike_count = r_spike_count;
    assign signature   = r_signature;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign step_err    = r_step_err;

endmodule
`default_nettype wire

// File: tb/tb_spike_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_collector
//  Description : Self-checking bench for spike_collector against a queue
//                based reference model, with directed and random phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_collector;

    localparam int STEPS = 2;
    localparam int CPS   = 64;
    localparam int DEPTH = 4;

    logic        neu_clk      = 1'b0;
    logic        rst_n        = 1'b0;
    logic        start        = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] packet_in    = '0;
    logic        receive_full;
    logic [7:0]  step_index;
    logic [7:0]  spike_count;
    logic [31:0] signature;
    logic        done;
    logic        overflow;
    logic        step_err;

    always #5 neu_clk = ~neu_clk;

    spike_collector #(
        .PKT_WIDTH    (32),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (2),
        .STEP_NUMBER  (STEPS),
        .CLK_PER_STEP (CPS),
        .CNT_WIDTH    (8)
    ) dut (
        .neu_clk      (neu_clk),
        .rst_n        (rst_n),
        .start        (start),
        .packet_in    (packet_in),
        .write_enable (write_enable),
        .receive_full (receive_full),
        .step_index   (step_index),
        .spike_count  (spike_count),
        .signature    (signature),
        .done         (done),
        .overflow     (overflow),
        .step_err     (step_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: phase 0 idle, 1 run, 2 flush, 3 done.
    int          m_ph;
    logic [31:0] m_q[$];
    int          m_step, m_run, m_cnt, m_cyc;
    logic [31:0] m_sig;
    bit          m_done, m_ovf, m_err;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic bit model_full();
        return ((m_ph == 1) || (m_ph == 2)) && (m_q.size() == DEPTH);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_q.delete(); m_step = 0; m_run = 0; m_cnt = 0; m_cyc = 0;
        m_sig = '0; m_done = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_update(input bit s, input bit we, input logic [31:0] pkt);
        bit          act, full, popv, pushv, was_empty;
        int          old_run;
        logic [31:0] v;
        act       = (m_ph == 1) || (m_ph == 2);
        full      = model_full();
        was_empty = (m_q.size() == 0);
        popv      = act && !was_empty;
        pushv     = act && we && !full;
        old_run   = m_run;
        if (we && full) m_ovf = 1;
        if (popv) begin
            v     = m_q.pop_front();
            m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ v;
        end
        if (pushv) m_q.push_back(pkt);
        case (m_ph)
            0: if (s) begin m_ph = 1; m_step = 0; m_run = 0; m_cyc = 0; end
            1: begin
                if (s) begin
                    m_cnt = sat(old_run + int'(popv));
                    m_run = 0; m_cyc = 0;
                    if (m_step == STEPS - 1) m_ph = 2;
                    else m_step++;
                end else begin
                    m_run = sat(old_run + int'(popv));
                    if (m_cyc < CPS) m_cyc++;
                    if (m_cyc == CPS) m_err = 1;
                end
            end
            2: begin
                m_run = sat(old_run + int'(popv));
                if (was_empty) begin m_ph = 3; m_cnt = old_run; m_done = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        chk("receive_full", receive_full, 32'(model_full()));
        chk("step_index",   step_index,   32'(m_step));
        chk("spike_count",  spike_count,  32'(m_cnt));
        chk("signature",    signature,    m_sig);
        chk("done",         done,         32'(m_done));
        chk("overflow",     overflow,     32'(m_ovf));
        chk("step_err",     step_err,     32'(m_err));
    endtask

    task automatic tick(input bit s, input bit we, input logic [31:0] pkt);
        @(negedge neu_clk);
        check_outputs();
        start = s; write_enable = we; packet_in = pkt;
        model_update(s, we, pkt);
        @(posedge neu_clk);
    endtask

    // Asynchronous reset placed between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(negedge neu_clk);
        #2;
        rst_n = 1'b0; start = 1'b0; write_enable = 1'b0;
        #1;
        chk("rst_full", receive_full, 0);
        chk("rst_step", step_index,   0);
        chk("rst_cnt",  spike_count,  0);
        chk("rst_sig",  signature,    0);
        chk("rst_done", done,         0);
        chk("rst_ovf",  overflow,     0);
        chk("rst_err",  step_err,     0);
        model_reset();
        @(negedge neu_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();

        // Test 1: two-step run with 3 then 1 packets.
        async_reset();
        tick(1, 0, 0);
        tick(0, 1, 32'hA); tick(0, 1, 32'hB); tick(0, 1, 32'hC);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        #1 chk("t1_cnt_step0", spike_count, 3);
        tick(0, 1, 32'hD);
        repeat (2) tick(0, 0, 0);
        tick(1, 0, 0);
        #1 chk("t1_cnt_step1", spike_count, 1);
        chk("t1_done_early", done, 0);
        tick(0, 0, 0);
        #1 chk("t1_done", done, 1);
        chk("t1_step_final", step_index, 1);
        tick(1, 0, 0);
        tick(0, 0, 0);

        // Test 2: signature of 1 then 2 cancels to zero.
        async_reset();
        tick(1, 0, 0);
        tick(0, 1, 32'h1);
        tick(0, 1, 32'h2);
        #1 chk("t2_sig_after1", signature, 32'h1);
        tick(0, 0, 0);
        #1 chk("t2_sig_after2", signature, 32'h0);
        tick(0, 0, 0);

        // Test 3: writes in IDLE are ignored.
        async_reset();
        repeat (6) tick(0, 1, $urandom);
        #1 chk("t3_full", receive_full, 0);
        chk("t3_ovf", overflow, 0);
        chk("t3_sig", signature, 0);
        tick(0, 0, 0);

        // Test 4: 5-packet burst keeps pace with pop.
        async_reset();
        tick(1, 0, 0);
        repeat (5) tick(0, 1, $urandom);
        repeat (3) tick(0, 0, 0);
        tick(1, 0, 0);
        #1 chk("t4_ovf", overflow, 0);
        chk("t4_cnt", spike_count, 5);

        // Test 5: watchdog boundary.
        async_reset();
        tick(1, 0, 0);
        repeat (CPS - 1) tick(0, 0, 0);
        #1 chk("t5_err_before", step_err, 0);
        tick(0, 0, 0);
        #1 chk("t5_err_at", step_err, 1);
        repeat (5) tick(0, 0, 0);
        tick(1, 0, 0);
        #1 chk("t5_err_sticky", step_err, 1);
        tick(0, 0, 0);

        // Test 6: reset during FLUSH with a packet queued, then restart.
        async_reset();
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 32'hDEAD_BEEF);
        async_reset();
        tick(1, 0, 0);
        #1 chk("t6_restart_step", step_index, 0);
        repeat (3) tick(0, 0, 0);
        #1 chk("t6_sig_clean", signature, 0);

        // Random runs against the model.
        for (int run = 0; run < 8; run++) begin
            int prob;
            async_reset();
            prob = (run % 2 == 0) ? 10 : 90;
            for (int c = 0; c < 500; c++) begin
                bit s, we;
                s  = ($urandom % prob == 0) || (m_ph == 0 && ($urandom % 4 == 0));
                we = ($urandom % 2 == 1) && (m_ph != 2);
                tick(s, we, $urandom);
                if (m_ph == 3) break;
            end
            repeat (3) tick($urandom % 2 == 1, $urandom % 2 == 1, $urandom);
        end

        @(negedge neu_clk);
        check_outputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
